// File: rtl/stall_mem_pkg.sv
// Shared encodings for the multi-cycle data-memory responder (stall_mem_resp).
package stall_mem_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_RD,
        OP_WR,
        OP_ERR
    } op_t;

endpackage

// File: rtl/stall_mem_array.sv
// 2**WORD_ADDR_W x 16 storage: synchronous write, registered read output.
module stall_mem_array #(
    parameter int unsigned WORD_ADDR_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic                   re,
    input  logic [WORD_ADDR_W-1:0] idx,
    input  logic [15:0]            wdata,
    output logic [15:0]            rdata
);

    logic [15:0] mem [2**WORD_ADDR_W];

    // Storage is deliberately left out of reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/stall_mem_resp.sv
// Multi-cycle data-memory responder: stalls for LATENCY-1 cycles, then pulses done.
// Optional: define STALL_MEM_ALIGN_CHECK_EN to flag odd byte addresses as errors.
module stall_mem_resp
    import stall_mem_pkg::*;
#(
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned WORD_ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        done,
    output logic        stall,
    output logic        err
);

    localparam bit SINGLE = (LATENCY == 1);

    state_t                 state, state_next;
    logic [CNT_W-1:0]       cnt, cnt_next;
    op_t                    op_q, req_op, acc_op;
    logic [WORD_ADDR_W-1:0] idx_q, req_idx, acc_idx;
    logic [15:0]            wdata_q, acc_data;
    logic                   accept, enter_done;
    logic                   mem_we, mem_re;
    logic                   unused_addr;

    assign req_idx     = addr[WORD_ADDR_W:1];
    assign unused_addr = ^{addr[15:WORD_ADDR_W+1], addr[0]};

    always_comb begin
        req_op = OP_RD;
        if (req_rd && req_wr) begin
            req_op = OP_ERR;
`ifdef STALL_MEM_ALIGN_CHECK_EN
        end else if (addr[0]) begin
            req_op = OP_ERR;
`endif
        end else if (req_wr) begin
            req_op = OP_WR;
        end
    end

    assign accept = (state != ST_WAIT) && (req_rd || req_wr);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        enter_done = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    if (SINGLE) begin
                        state_next = ST_DONE;
                        enter_done = 1'b1;
                        cnt_next   = '0;
                    end else begin
                        state_next = ST_WAIT;
                        cnt_next   = CNT_W'(LATENCY - 1);
                    end
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    state_next = ST_DONE;
                    enter_done = 1'b1;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            op_q    <= OP_RD;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                op_q    <= req_op;
                idx_q   <= req_idx;
                wdata_q <= data_in;
            end
        end
    end

    // With LATENCY=1 the access happens on the acceptance edge itself, so the
    // array must see the incoming request rather than the latched copy.
    assign acc_op   = SINGLE ? req_op  : op_q;
    assign acc_idx  = SINGLE ? req_idx : idx_q;
    assign acc_data = SINGLE ? data_in : wdata_q;

    assign mem_we = rst && enter_done && (acc_op == OP_WR);
    assign mem_re = enter_done && (acc_op == OP_RD);

    stall_mem_array #(
        .WORD_ADDR_W(WORD_ADDR_W)
    ) u_array (
        .clk  (clk),
        .rst  (rst),
        .we   (mem_we),
        .re   (mem_re),
        .idx  (acc_idx),
        .wdata(acc_data),
        .rdata(data_out)
    );

    assign done  = (state == ST_DONE);
    assign stall = (state == ST_WAIT);
    assign err   = (state == ST_DONE) && (op_q == OP_ERR);

endmodule

// File: tb/tb_stall_mem_resp.sv
// Directed plus randomized bench for stall_mem_resp against an array-based reference model.
module tb_stall_mem_resp;

    localparam int unsigned LAT = 2;
    localparam int unsigned AW  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_rd = 1'b0;
    logic        req_wr = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] data_in = '0;
    logic [15:0] data_out;
    logic        done, stall, err;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] mem_m [256];
    logic [15:0] dout_m = '0;

    stall_mem_resp #(
        .LATENCY    (LAT),
        .WORD_ADDR_W(AW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req_rd  (req_rd),
        .req_wr  (req_wr),
        .addr    (addr),
        .data_in (data_in),
        .data_out(data_out),
        .done    (done),
        .stall   (stall),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; ends at the negedge of the done cycle.
    task automatic access(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d);
        int  idx;
        bit  e;
        idx = (int'(a) / 2) % 256;
        e   = rd && wr;
`ifdef STALL_MEM_ALIGN_CHECK_EN
        if (a[0]) e = 1'b1;
`endif
        req_rd = rd; req_wr = wr; addr = a; data_in = d;
        @(posedge clk); #1;
        // a conflicting write held during the busy window must be ignored
        req_rd = 1'b0; req_wr = 1'b1; data_in = ~d;
        for (int i = 1; i < int'(LAT); i++) begin
            @(negedge clk);
            check("stall_busy", {15'd0, stall}, 16'd1);
            check("done_early", {15'd0, done}, 16'd0);
            @(posedge clk); #1;
        end
        req_rd = 1'b0; req_wr = 1'b0; addr = 16'($urandom); data_in = 16'($urandom);
        if (!e) begin
            if (wr) mem_m[idx] = d;
            else    dout_m = mem_m[idx];
        end
        @(negedge clk);
        check("done_pulse", {15'd0, done}, 16'd1);
        check("stall_in_done", {15'd0, stall}, 16'd0);
        check("err", {15'd0, err}, {15'd0, e});
        check("data_out", data_out, dout_m);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_done", {15'd0, done}, 16'd0);
            check("idle_stall", {15'd0, stall}, 16'd0);
            check("idle_err", {15'd0, err}, 16'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] a;
        int          op;

        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_data_out", data_out, 16'h0000);
        check("rst_done", {15'd0, done}, 16'd0);
        check("rst_stall", {15'd0, stall}, 16'd0);
        check("rst_err", {15'd0, err}, 16'd0);
        rst = 1'b1;
        idle(2);

        access(1'b0, 1'b1, 16'h0010, 16'hBEEF);
        idle(1);
        access(1'b1, 1'b0, 16'h0010, 16'h0000);
        idle(1);

        access(1'b0, 1'b1, 16'h0020, 16'h1234);
        access(1'b1, 1'b0, 16'h0020, 16'h0000);
        idle(1);

        access(1'b0, 1'b1, 16'h0002, 16'hA5A5);
        access(1'b1, 1'b0, 16'h0202, 16'h0000);
        idle(1);

        access(1'b1, 1'b1, 16'h0010, 16'h5555);
        access(1'b1, 1'b0, 16'h0010, 16'h0000);
        access(1'b1, 1'b0, 16'h0011, 16'h0000);
        access(1'b1, 1'b0, 16'h0002, 16'h0000);
        idle(1);

        access(1'b0, 1'b1, 16'h0030, 16'h7777);
        idle(1);
        req_wr = 1'b1; addr = 16'h0030; data_in = 16'hFFFF;
        @(posedge clk); #1;
        req_wr = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        dout_m = '0;
        @(negedge clk);
        check("midrst_done", {15'd0, done}, 16'd0);
        check("midrst_stall", {15'd0, stall}, 16'd0);
        check("midrst_err", {15'd0, err}, 16'd0);
        check("midrst_data_out", data_out, 16'h0000);
        idle(2);
        access(1'b1, 1'b0, 16'h0030, 16'h0000);
        idle(1);

        for (int k = 0; k < 16; k++) begin
            a = 16'($urandom);
            a[8:1] = 8'(8'h40 + k);
            a[0] = 1'b0;
            access(1'b0, 1'b1, a, 16'($urandom));
        end
        for (int k = 0; k < 60; k++) begin
            a = 16'($urandom);
            a[8:1] = 8'(8'h40 + $urandom_range(0, 15));
            op = int'($urandom_range(0, 9));
            if (op < 4)      access(1'b0, 1'b1, a, 16'($urandom));
            else if (op < 8) access(1'b1, 1'b0, a, 16'($urandom));
            else             access(1'b1, 1'b1, a, 16'($urandom));
            if ($urandom_range(0, 1) == 1) idle(1);
        end
        idle(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
